// File: rtl/irda_fir_flag_det_gen.sv
// FIR (4PPM) flag detector/deframer: matches preamble/start/stop/break on a sliding
// window, qualifies start on PA_MIN preambles, gates data bits past flags and packs bytes.
module irda_fir_flag_det_gen #(
    parameter int unsigned      SR_W    = 32,
    parameter int unsigned      PA_W    = 16,
    parameter int unsigned      BRK_W   = 8,
    parameter logic [PA_W-1:0]  PA_PAT  = 16'b1000000010101000,
    parameter logic [SR_W-1:0]  STA_PAT = 32'h0C0C6060,
    parameter logic [SR_W-1:0]  STO_PAT = 32'h0C0C0606,
    parameter int unsigned      PA_MIN  = 4
) (
    input  logic       clk,
    input  logic       wb_rst_i,
    input  logic       fd_restart,
    input  logic       fir_rx8_enable,
    input  logic       bs_o,
    output logic       pa_det,
    output logic       sta_det,
    output logic       sto_det,
    output logic       break_det,
    output logic [1:0] state_o,
    output logic       fd_data_bit,
    output logic       fd_o,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_abort,
    output logic       frame_partial
);

    localparam int unsigned FW = $clog2(SR_W + 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          r_state;
    logic [SR_W-1:0] r_sr;
    logic [FW-1:0]   r_front;
    logic [7:0]      r_pa_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic [7:0]      r_byte;
    logic            r_pa_det, r_sta_det, r_sto_det, r_brk_det;
    logic            r_byte_valid, r_frame_start, r_frame_end, r_frame_abort, r_frame_partial;

    logic            w_en;
    logic [SR_W-1:0] w_win;
    logic            w_pa, w_sta, w_sto, w_brk;
    logic            w_in_data, w_sta_acc;
    logic [2:0]      w_cnt_nxt;
    logic [7:0]      w_pa_cnt_nxt;
    logic [FW-1:0]   w_front_nxt;
    logic [7:0]      w_shreg_nxt;

    assign w_en      = fir_rx8_enable;
    assign w_win     = {r_sr[SR_W-2:0], bs_o};
    assign w_pa      = w_en && (w_win[SR_W-1 -: PA_W] == PA_PAT);
    assign w_sta     = w_en && (w_win == STA_PAT);
    assign w_sto     = w_en && (w_win == STO_PAT);
    assign w_brk     = w_en && (w_win[SR_W-1 -: BRK_W] == '0);
    assign w_in_data = (r_state == ST_DATA);
    assign w_sta_acc = w_sta && (r_state == ST_SYNC);

    // r_front counts flag-free bits in the window; the top bit is data once it reaches SR_W
    assign fd_o        = r_sr[SR_W-1];
    assign fd_data_bit = w_en && w_in_data && (r_front == FW'(SR_W));
    assign w_cnt_nxt   = r_bit_cnt + 3'(fd_data_bit);

    always_comb begin
        w_front_nxt = r_front;
        if (w_pa && !w_in_data)
            w_front_nxt = FW'(SR_W - PA_W);
        else if (w_sta || w_sto)
            w_front_nxt = '0;
        else if (w_brk)
            w_front_nxt = FW'(SR_W - BRK_W);
        else if (r_front != FW'(SR_W))
            w_front_nxt = r_front + FW'(1);
    end

    always_comb begin
        w_pa_cnt_nxt = r_pa_cnt;
        if (w_brk || w_sta_acc)
            w_pa_cnt_nxt = '0;
        else if (w_pa && !w_in_data && (r_pa_cnt != 8'hFF))
            w_pa_cnt_nxt = r_pa_cnt + 8'd1;
    end

    always_comb begin
        w_shreg_nxt            = r_shreg;
        w_shreg_nxt[r_bit_cnt] = fd_o;
    end

    // Window, pointer, preamble counter, byte packer and frame FSM
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_HUNT;  r_sr <= '0;  r_front <= '0;  r_pa_cnt <= '0;
            r_bit_cnt <= '0;  r_shreg <= '0;  r_byte <= '0;
            r_pa_det <= 1'b0;  r_sta_det <= 1'b0;  r_sto_det <= 1'b0;  r_brk_det <= 1'b0;
            r_byte_valid <= 1'b0;  r_frame_start <= 1'b0;  r_frame_end <= 1'b0;
            r_frame_abort <= 1'b0;  r_frame_partial <= 1'b0;
        end else if (fd_restart) begin
            r_state <= ST_HUNT;  r_sr <= '0;  r_front <= '0;  r_pa_cnt <= '0;
            r_bit_cnt <= '0;  r_shreg <= '0;  r_byte <= '0;
            r_pa_det <= 1'b0;  r_sta_det <= 1'b0;  r_sto_det <= 1'b0;  r_brk_det <= 1'b0;
            r_byte_valid <= 1'b0;  r_frame_start <= 1'b0;  r_frame_end <= 1'b0;
            r_frame_abort <= 1'b0;  r_frame_partial <= 1'b0;
        end else begin
            r_pa_det        <= w_pa;
            r_sta_det       <= w_sta;
            r_sto_det       <= w_sto;
            r_brk_det       <= w_brk;
            r_byte_valid    <= 1'b0;
            r_frame_start   <= 1'b0;
            r_frame_end     <= 1'b0;
            r_frame_abort   <= 1'b0;
            r_frame_partial <= 1'b0;
            if (w_en) begin
                r_sr     <= w_win;
                r_front  <= w_front_nxt;
                r_pa_cnt <= w_pa_cnt_nxt;
                if (fd_data_bit) begin
                    r_shreg   <= w_shreg_nxt;
                    r_bit_cnt <= w_cnt_nxt;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte       <= w_shreg_nxt;
                        r_byte_valid <= 1'b1;
                    end
                end
                case (r_state)
                    ST_HUNT: begin
                        if (w_pa_cnt_nxt >= 8'(PA_MIN))
                            r_state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (w_sta) begin
                            r_state       <= ST_DATA;
                            r_frame_start <= 1'b1;
                            r_bit_cnt     <= '0;
                            r_shreg       <= '0;
                        end else if (w_brk) begin
                            r_state <= ST_HUNT;
                        end
                    end
                    ST_DATA: begin
                        // The bit leaving alongside a stop/break is counted before the frame closes
                        if (w_sto) begin
                            r_state         <= ST_HUNT;
                            r_frame_end     <= 1'b1;
                            r_frame_partial <= (w_cnt_nxt != 3'd0);
                            r_bit_cnt       <= '0;
                            r_shreg         <= '0;
                        end else if (w_brk) begin
                            r_state       <= ST_HUNT;
                            r_frame_abort <= 1'b1;
                            r_bit_cnt     <= '0;
                            r_shreg       <= '0;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign state_o       = r_state;
    assign byte_o        = r_byte;
    assign pa_det        = r_pa_det;
    assign sta_det       = r_sta_det;
    assign sto_det       = r_sto_det;
    assign break_det     = r_brk_det;
    assign byte_valid    = r_byte_valid;
    assign frame_start   = r_frame_start;
    assign frame_end     = r_frame_end;
    assign frame_abort   = r_frame_abort;
    assign frame_partial = r_frame_partial;

endmodule

// File: tb/tb_irda_fir_flag_det_gen.sv
// Directed bench for irda_fir_flag_det_gen: framed streams, short/aborted frames,
// restart and sparse bit strobes, each checked against hand-derived outcomes.
module tb_irda_fir_flag_det_gen;

    localparam logic [15:0] PA  = 16'b1000000010101000;
    localparam logic [31:0] STA = 32'h0C0C6060;
    localparam logic [31:0] STO = 32'h0C0C0606;

    logic       clk = 1'b0;
    logic       wb_rst_i, fd_restart, fir_rx8_enable, bs_o;
    logic       pa_det, sta_det, sto_det, break_det;
    logic [1:0] state_o;
    logic       fd_data_bit, fd_o;
    logic [7:0] byte_o;
    logic       byte_valid, frame_start, frame_end, frame_abort, frame_partial;

    int n_chk  = 0;
    int n_fail = 0;
    int c_pa, c_sta, c_sto, c_brk, c_fs, c_fe, c_fa, c_fp, c_bv, c_db;
    logic [7:0] bytes[$];

    irda_fir_flag_det_gen dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .fd_restart(fd_restart),
        .fir_rx8_enable(fir_rx8_enable), .bs_o(bs_o),
        .pa_det(pa_det), .sta_det(sta_det), .sto_det(sto_det), .break_det(break_det),
        .state_o(state_o), .fd_data_bit(fd_data_bit), .fd_o(fd_o),
        .byte_o(byte_o), .byte_valid(byte_valid), .frame_start(frame_start),
        .frame_end(frame_end), .frame_abort(frame_abort), .frame_partial(frame_partial)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        c_pa = 0; c_sta = 0; c_sto = 0; c_brk = 0; c_fs = 0;
        c_fe = 0; c_fa = 0; c_fp = 0; c_bv = 0; c_db = 0;
        bytes.delete();
    endtask

    task automatic sample(input bit en_was);
        c_pa  += int'(pa_det);      c_sta += int'(sta_det);
        c_sto += int'(sto_det);     c_brk += int'(break_det);
        c_fs  += int'(frame_start); c_fe  += int'(frame_end);
        c_fa  += int'(frame_abort); c_fp  += int'(frame_partial);
        c_bv  += int'(byte_valid);
        if (byte_valid) bytes.push_back(byte_o);
        if (!en_was)
            chk("pulses_after_en_low",
                32'({pa_det, sta_det, sto_det, break_det, byte_valid,
                     frame_start, frame_end, frame_abort, frame_partial}), 32'd0);
    endtask

    task automatic strobe(input bit b);
        fir_rx8_enable = 1'b1;
        bs_o = b;
        #1;
        if (fd_data_bit) c_db++;
        @(posedge clk); #1;
        sample(1'b1);
    endtask

    task automatic idle();
        fir_rx8_enable = 1'b0;
        bs_o = 1'($urandom);
        #1;
        chk("fd_data_bit_en_low", 32'(fd_data_bit), 32'd0);
        @(posedge clk); #1;
        sample(1'b0);
    endtask

    task automatic send(input logic [31:0] v, input int n, input bit msb_first, input bit sparse);
        for (int i = 0; i < n; i++) begin
            strobe(msb_first ? v[n-1-i] : v[i]);
            if (sparse) begin
                idle();
                idle();
            end
        end
    endtask

    task automatic send_head(input bit sparse);
        for (int k = 0; k < 4; k++) send(32'(PA), 16, 1'b1, sparse);
        send(STA, 32, 1'b1, sparse);
    endtask

    task automatic do_reset();
        fir_rx8_enable = 1'b0;
        bs_o = 1'b0;
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        clr_counts();
    endtask

    initial begin
        wb_rst_i = 1'b1; fd_restart = 1'b0; fir_rx8_enable = 1'b0; bs_o = 1'b0;
        clr_counts();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_byte", 32'(byte_o), 32'd0);
        chk("rst_pulses", 32'({pa_det, sta_det, sto_det, break_det, byte_valid,
                                frame_start, frame_end, frame_abort, frame_partial}), 32'd0);
        chk("rst_fd_o", 32'(fd_o), 32'd0);
        wb_rst_i = 1'b0;

        // Full frame: 4 preambles, start, 0xA5 0x3C, stop
        do_reset();
        send_head(1'b0);
        chk("f1_state_data", 32'(state_o), 32'd2);
        send(32'h3CA5, 16, 1'b0, 1'b0);
        send(STO, 32, 1'b1, 1'b0);
        chk("f1_pa_det", 32'(c_pa), 32'd4);
        chk("f1_sta_det", 32'(c_sta), 32'd1);
        chk("f1_sto_det", 32'(c_sto), 32'd1);
        chk("f1_frame_start", 32'(c_fs), 32'd1);
        chk("f1_data_bits", 32'(c_db), 32'd16);
        chk("f1_byte_cnt", 32'(c_bv), 32'd2);
        chk("f1_byte0", 32'(bytes[0]), 32'hA5);
        chk("f1_byte1", 32'(bytes[1]), 32'h3C);
        chk("f1_frame_end", 32'(c_fe), 32'd1);
        chk("f1_partial", 32'(c_fp), 32'd0);
        chk("f1_abort", 32'(c_fa), 32'd0);
        chk("f1_state_end", 32'(state_o), 32'd0);

        // Single preamble does not qualify a start flag
        do_reset();
        send(32'(PA), 16, 1'b1, 1'b0);
        send(STA, 32, 1'b1, 1'b0);
        chk("f2_pa_det", 32'(c_pa), 32'd1);
        chk("f2_sta_det", 32'(c_sta), 32'd1);
        chk("f2_frame_start", 32'(c_fs), 32'd0);
        chk("f2_state", 32'(state_o), 32'd0);

        // 12 data bits: one byte then partial at stop
        do_reset();
        send_head(1'b0);
        send(32'hB5A, 12, 1'b0, 1'b0);
        send(STO, 32, 1'b1, 1'b0);
        chk("f3_data_bits", 32'(c_db), 32'd12);
        chk("f3_byte_cnt", 32'(c_bv), 32'd1);
        chk("f3_byte0", 32'(bytes[0]), 32'h5A);
        chk("f3_frame_end", 32'(c_fe), 32'd1);
        chk("f3_partial", 32'(c_fp), 32'd1);

        // One byte then a zero run: break aborts the frame
        do_reset();
        send_head(1'b0);
        clr_counts();
        send(32'hA5, 8, 1'b0, 1'b0);
        send(32'h0, 32, 1'b0, 1'b0);
        chk("f4_break_det", 32'(c_brk), 32'd1);
        chk("f4_abort", 32'(c_fa), 32'd1);
        chk("f4_frame_end", 32'(c_fe), 32'd0);
        chk("f4_state", 32'(state_o), 32'd0);

        // Restart in the middle of DATA
        do_reset();
        send_head(1'b0);
        send(32'hA5, 8, 1'b0, 1'b0);
        chk("f5_state_data", 32'(state_o), 32'd2);
        clr_counts();
        fd_restart = 1'b1; fir_rx8_enable = 1'b1; bs_o = 1'b1;
        @(posedge clk); #1;
        fd_restart = 1'b0;
        sample(1'b1);
        chk("f5_state", 32'(state_o), 32'd0);
        chk("f5_pa_cnt", 32'(dut.r_pa_cnt), 32'd0);
        chk("f5_front", 32'(dut.r_front), 32'd0);
        send(32'h0, 32, 1'b0, 1'b0);
        send(32'h0, 8, 1'b0, 1'b0);
        chk("f5_frame_pulses", 32'(c_fs + c_fe + c_fa + c_fp), 32'd0);
        chk("f5_byte_cnt", 32'(c_bv), 32'd0);

        // Same frame as the first, strobed 1-of-3 with noise between strobes
        do_reset();
        send_head(1'b1);
        send(32'h3CA5, 16, 1'b0, 1'b1);
        send(STO, 32, 1'b1, 1'b1);
        chk("f6_frame_start", 32'(c_fs), 32'd1);
        chk("f6_byte_cnt", 32'(c_bv), 32'd2);
        chk("f6_byte0", 32'(bytes[0]), 32'hA5);
        chk("f6_byte1", 32'(bytes[1]), 32'h3C);
        chk("f6_frame_end", 32'(c_fe), 32'd1);
        chk("f6_partial", 32'(c_fp), 32'd0);
        chk("f6_state", 32'(state_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
